we_event_monitor: RTL

//   Parametrised event monitor in the weClk domain. Takes N_CH done/flag signals

---
 rtl/we_event_monitor.sv | 97 +++++++++
 1 files changed

// File: rtl/we_event_monitor.sv
// Per-channel event monitor: edge/level counting with wrap or saturate, sticky and
// overflow flags, masked clear, and a snapshot/readback path for host counter reads.
module we_event_monitor #(
  parameter int N_CH = 8,
  parameter int CNT_W = 32,
  parameter bit SATURATE = 1'b0,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_CH-1:0]  evt_in,
  input  logic [N_CH-1:0]  cnt_mode,
  input  logic             clr,
  input  logic [N_CH-1:0]  clr_mask,
  input  logic             snap,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_CH-1:0]  trig_out,
  output logic [N_CH-1:0]  sticky,
  output logic [N_CH-1:0]  ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N_CH-1:0]  evt_q;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  inc;
  logic [N_CH-1:0]  clr_hit;
  logic [CNT_W-1:0] cnt    [N_CH];
  logic [CNT_W-1:0] shadow [N_CH];

  always_comb begin
    rise    = evt_in & ~evt_q;
    clr_hit = {N_CH{clr}} & clr_mask;
    inc     = '0;
    for (int i = 0; i < N_CH; i++) begin
      inc[i] = en & (cnt_mode[i] ? evt_in[i] : rise[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q    <= '0;
      trig_out <= '0;
    end else begin
      evt_q    <= evt_in;
      trig_out <= {N_CH{en}} & rise;
    end
  end

  // Shadows sample the pre-update count, so snap+clr together reads and clears atomically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      sticky <= '0;
      ovf    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (snap) begin
          shadow[i] <= cnt[i];
        end
        if (clr_hit[i]) begin
          cnt[i] <= inc[i] ? CNT_ONE : '0;
          ovf[i] <= 1'b0;
        end else if (inc[i]) begin
          if (cnt[i] == CNT_MAX) begin
            cnt[i] <= SATURATE ? CNT_MAX : '0;
            ovf[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
        end
        if (rise[i]) begin
          sticky[i] <= 1'b1;
        end else if (clr_hit[i]) begin
          sticky[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (int'(rd_sel) < N_CH) begin
      rd_data <= shadow[rd_sel];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
